// File: rtl/store_commit_ctrl_if.sv
// ---------------------------------------------------------------------------
// store_commit_ctrl_if
//   Bundles every non-clock signal of the store commit controller.
//   master : the controller side (drives sq_pop, dc_req_*, status).
//   slave  : the environment side (commit stage, store queue, dcache).
//
// Handshake semantics (dc_req_*):
//   A write beat transfers on a cycle where dc_req_valid && dc_req_ready.
//   Once dc_req_valid is high, dc_req_addr/data/wstrb/uncached stay stable
//   and dc_req_valid stays high until that transfer cycle; ready may toggle
//   freely and never depends combinationally on valid.
//   dc_resp_valid is a one-cycle completion pulse for an uncached beat and
//   is only meaningful while the controller waits for it.
// ---------------------------------------------------------------------------
interface store_commit_ctrl_if #(
  parameter int CNT_W = 4
);
  logic             commit_store1_valid;
  logic             commit_store2_valid;
  logic             sq_head_valid;
  logic [31:0]      sq_head_addr;
  logic [31:0]      sq_head_data;
  logic [3:0]       sq_head_wstrb;
  logic             sq_head_uncached;
  logic             sq_pop;
  logic             dc_req_valid;
  logic [31:0]      dc_req_addr;
  logic [31:0]      dc_req_data;
  logic [3:0]       dc_req_wstrb;
  logic             dc_req_uncached;
  logic             dc_req_ready;
  logic             dc_resp_valid;
  logic [CNT_W-1:0] pending_cnt;
  logic             store_full;
  logic             drain_empty;

  modport master (
    input  commit_store1_valid, commit_store2_valid,
    input  sq_head_valid, sq_head_addr, sq_head_data, sq_head_wstrb, sq_head_uncached,
    input  dc_req_ready, dc_resp_valid,
    output sq_pop,
    output dc_req_valid, dc_req_addr, dc_req_data, dc_req_wstrb, dc_req_uncached,
    output pending_cnt, store_full, drain_empty
  );

  modport slave (
    output commit_store1_valid, commit_store2_valid,
    output sq_head_valid, sq_head_addr, sq_head_data, sq_head_wstrb, sq_head_uncached,
    output dc_req_ready, dc_resp_valid,
    input  sq_pop,
    input  dc_req_valid, dc_req_addr, dc_req_data, dc_req_wstrb, dc_req_uncached,
    input  pending_cnt, store_full, drain_empty
  );
endinterface

// File: rtl/store_commit_ctrl.sv
// ---------------------------------------------------------------------------
// store_commit_ctrl
//   Drains architecturally committed stores from the store-queue head to the
//   dcache write port, strictly in order. Counts committed-but-unpopped
//   stores (up to two commits per cycle), pops the SQ head, presents a
//   registered valid/ready write request, and blocks on uncached stores
//   until their write response.
// Ports
//   clk         : clock
//   resetn      : asynchronous active-low reset
//   bus         : store_commit_ctrl_if.master (commit, SQ head, dcache
//                 request/response, pending_cnt/store_full/drain_empty)
//   o_dbg_state : current FSM state (0 IDLE, 1 REQ, 2 WAIT)
// ---------------------------------------------------------------------------
module store_commit_ctrl #(
  parameter int PENDING_MAX = 8,
  parameter int CNT_W       = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  store_commit_ctrl_if.master        bus,
  output logic [1:0]                 o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam logic [CNT_W:0]   MAX_W  = (CNT_W+1)'(PENDING_MAX);
  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(PENDING_MAX);
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(PENDING_MAX - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_addr;
  logic [31:0]      r_data;
  logic [3:0]       r_wstrb;
  logic             r_unc;

  logic             w_cnt_nz;
  logic             w_pop;
  logic [CNT_W:0]   w_inc_sum;
  logic [CNT_W:0]   w_cnt_sum;
  logic [CNT_W-1:0] w_cnt_next;

  assign w_cnt_nz = (r_cnt != '0);

  // The pop is decoded combinationally from registered state so that a
  // store committed in cycle t is popped in t+1 and requested in t+2.
  // In REQ a cached beat being accepted frees the request register, so the
  // next head can be loaded in the same cycle for 1 store/cycle throughput.
  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      S_IDLE:  w_pop = w_cnt_nz && bus.sq_head_valid;
      S_REQ:   w_pop = bus.dc_req_ready && !r_unc && w_cnt_nz && bus.sq_head_valid;
      default: w_pop = 1'b0;
    endcase
  end

  // One extra bit so the sum can exceed PENDING_MAX before saturation.
  // A pop only happens with r_cnt > 0, so the subtraction cannot wrap.
  assign w_inc_sum = {1'b0, r_cnt}
                   + {{CNT_W{1'b0}}, bus.commit_store1_valid}
                   + {{CNT_W{1'b0}}, bus.commit_store2_valid};
  assign w_cnt_sum = w_inc_sum - {{CNT_W{1'b0}}, w_pop};
  assign w_cnt_next = (w_cnt_sum > MAX_W) ? MAX_C : w_cnt_sum[CNT_W-1:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_wstrb <= '0;
      r_unc   <= 1'b0;
    end else begin
      r_cnt <= w_cnt_next;
      if (w_pop) begin
        r_addr  <= bus.sq_head_addr;
        r_data  <= bus.sq_head_data;
        r_wstrb <= bus.sq_head_wstrb;
        r_unc   <= bus.sq_head_uncached;
      end
      case (r_state)
        S_IDLE: begin
          if (w_pop) r_state <= S_REQ;
        end
        S_REQ: begin
          if (bus.dc_req_ready) begin
            if (r_unc)       r_state <= S_WAIT;
            else if (!w_pop) r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (bus.dc_resp_valid) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.sq_pop          = w_pop;
  assign bus.dc_req_valid    = (r_state == S_REQ);
  assign bus.dc_req_addr     = r_addr;
  assign bus.dc_req_data     = r_data;
  assign bus.dc_req_wstrb    = r_wstrb;
  assign bus.dc_req_uncached = r_unc;
  assign bus.pending_cnt     = r_cnt;
  assign bus.store_full      = (r_cnt >= FULL_C);
  assign bus.drain_empty     = !w_cnt_nz && (r_state == S_IDLE);
  assign o_dbg_state         = r_state;

  // Protocol checks on the commit stage and store queue.
  a_c2_needs_c1: assert property (@(posedge clk) disable iff (!resetn)
    bus.commit_store2_valid |-> bus.commit_store1_valid);
  a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
    w_inc_sum <= MAX_W);
  a_head_present: assert property (@(posedge clk) disable iff (!resetn)
    (r_state == S_IDLE && w_cnt_nz) |-> bus.sq_head_valid);

endmodule

// File: tb/tb_store_commit_ctrl.sv
`timescale 1ns/1ps
module tb_store_commit_ctrl;
  localparam int PENDING_MAX = 8;
  localparam int CNT_W       = 4;
  localparam int EW          = 69;  // {uncached, wstrb[3:0], addr[31:0], data[31:0]}

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       resetn;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  store_commit_ctrl_if #(.CNT_W(CNT_W)) bus ();

  store_commit_ctrl #(.PENDING_MAX(PENDING_MAX), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- bench state ----------------
  int n_cmp = 0;
  int n_bad = 0;

  logic [EW-1:0] sq_q[$];   // store queue contents, head at index 0
  logic [EW-1:0] exp_q[$];  // stores expected on the dcache port, in order

  // Reference model: pending count, one request slot, waiting-for-response flag
  int            m_pend;
  bit            m_slot_v;
  logic [EW-1:0] m_slot;
  bit            m_wait;

  // Values sampled at the last negedge
  bit            s_pop, s_valid, s_full, s_empty;
  int            s_cnt;
  logic [EW-1:0] s_req;
  int            n_pops, n_acc;
  logic [1:0]    idle_code;

  // ---------------- checks ----------------
  task automatic chk_i(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_e(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_head();
    logic [EW-1:0] h;
    if (sq_q.size() > 0) begin
      h = sq_q[0];
      bus.sq_head_valid    = 1'b1;
      bus.sq_head_uncached = h[68];
      bus.sq_head_wstrb    = h[67:64];
      bus.sq_head_addr     = h[63:32];
      bus.sq_head_data     = h[31:0];
    end else begin
      bus.sq_head_valid    = 1'b0;
      bus.sq_head_uncached = 1'b0;
      bus.sq_head_wstrb    = '0;
      bus.sq_head_addr     = '0;
      bus.sq_head_data     = '0;
    end
  endtask

  task automatic push_entry(input bit unc);
    logic [EW-1:0] e;
    e = {unc, 4'($urandom_range(1, 15)), 32'($urandom()), 32'($urandom())};
    sq_q.push_back(e);
    drive_head();
  endtask

  task automatic reset_env();
    bus.commit_store1_valid = 1'b0;
    bus.commit_store2_valid = 1'b0;
    bus.dc_req_ready        = 1'b0;
    bus.dc_resp_valid       = 1'b0;
    sq_q.delete();
    exp_q.delete();
    m_pend   = 0;
    m_slot_v = 1'b0;
    m_slot   = '0;
    m_wait   = 1'b0;
    drive_head();
  endtask

  // One clock cycle: compare at negedge, advance the model, then react to
  // the DUT's pop after the edge and clear the single-cycle inputs.
  task automatic tick();
    logic [EW-1:0] head;
    bit            exp_pop;
    @(negedge clk);
    s_pop   = bus.sq_pop;
    s_valid = bus.dc_req_valid;
    s_full  = bus.store_full;
    s_empty = bus.drain_empty;
    s_cnt   = int'(bus.pending_cnt);
    s_req   = {bus.dc_req_uncached, bus.dc_req_wstrb, bus.dc_req_addr, bus.dc_req_data};
    head    = {bus.sq_head_uncached, bus.sq_head_wstrb, bus.sq_head_addr, bus.sq_head_data};

    // A store leaves the SQ when stores are pending, a head exists, and the
    // request slot is free or a cached beat is leaving it this cycle.
    exp_pop = resetn && (m_pend > 0) && bus.sq_head_valid &&
              ((!m_slot_v && !m_wait) ||
               (m_slot_v && bus.dc_req_ready && !m_slot[68]));

    chk_i("sq_pop",       int'(s_pop),   int'(exp_pop));
    chk_i("pending_cnt",  s_cnt,         m_pend);
    chk_i("store_full",   int'(s_full),  int'(m_pend >= PENDING_MAX - 1));
    chk_i("drain_empty",  int'(s_empty), int'(m_pend == 0 && !m_slot_v && !m_wait));
    chk_i("dc_req_valid", int'(s_valid), int'(m_slot_v));
    if (m_slot_v) chk_e("dc_req_fields", s_req, m_slot);
    if (m_slot_v || m_wait) chk_i("dbg_state_busy", int'(dbg_state != idle_code), 1);

    if (s_pop) n_pops++;
    if (resetn && s_valid && bus.dc_req_ready) begin
      n_acc++;
      if (exp_q.size() == 0) chk_i("sb_unexpected_beat", 1, 0);
      else                   chk_e("sb_order", s_req, exp_q.pop_front());
    end

    if (resetn) begin
      if (exp_pop) exp_q.push_back(head);
      if (m_wait && bus.dc_resp_valid) m_wait = 1'b0;
      if (m_slot_v && bus.dc_req_ready) begin
        m_slot_v = 1'b0;
        if (m_slot[68]) m_wait = 1'b1;
      end
      if (exp_pop) begin
        m_slot_v = 1'b1;
        m_slot   = head;
      end
      m_pend = m_pend + int'(bus.commit_store1_valid) + int'(bus.commit_store2_valid) - int'(exp_pop);
      if (m_pend > PENDING_MAX) m_pend = PENDING_MAX;
    end

    @(posedge clk);
    #1;
    if (s_pop && sq_q.size() > 0) void'(sq_q.pop_front());
    drive_head();
    bus.commit_store1_valid = 1'b0;
    bus.commit_store2_valid = 1'b0;
    bus.dc_resp_valid       = 1'b0;
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    reset_env();
    repeat (2) tick();
    resetn = 1'b1;
  endtask

  task automatic drain(input string name);
    int k;
    bus.dc_req_ready = 1'b1;
    k = 0;
    while (k < 200 && !(s_empty && m_pend == 0 && !m_slot_v && !m_wait)) begin
      if (m_wait) bus.dc_resp_valid = 1'b1;
      tick();
      k++;
    end
    chk_i({name, "_drained"}, int'(s_empty), 1);
    chk_i({name, "_sb_empty"}, exp_q.size(), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [EW-1:0] e0, e1;
    int            exp_cnts[5];
    int            pops0, acc0, avail, n;

    n_pops = 0;
    n_acc  = 0;
    resetn = 1'b0;
    reset_env();
    #1;
    idle_code = dbg_state;  // reset state is IDLE
    repeat (2) tick();
    chk_i("reset_cnt",   s_cnt, 0);
    chk_i("reset_empty", int'(s_empty), 1);
    chk_i("reset_valid", int'(s_valid), 0);
    resetn = 1'b1;

    // Single cached store
    apply_reset();
    bus.dc_req_ready = 1'b1;
    push_entry(1'b0);
    e0 = sq_q[0];
    bus.commit_store1_valid = 1'b1;
    tick();                                          // t0
    chk_i("single_cnt_t0", s_cnt, 0);
    tick();                                          // t1
    chk_i("single_pop_t1", int'(s_pop), 1);
    chk_i("single_cnt_t1", s_cnt, 1);
    tick();                                          // t2
    chk_i("single_valid_t2", int'(s_valid), 1);
    chk_e("single_req_t2", s_req, e0);
    tick();                                          // t3
    chk_i("single_empty_t3", int'(s_empty), 1);
    chk_i("single_valid_t3", int'(s_valid), 0);

    // Dual commit of 4 cached stores
    apply_reset();
    bus.dc_req_ready = 1'b1;
    repeat (4) push_entry(1'b0);
    exp_cnts = '{2, 3, 2, 1, 0};
    acc0 = n_acc;
    bus.commit_store1_valid = 1'b1; bus.commit_store2_valid = 1'b1;
    tick();                                          // t0
    bus.commit_store1_valid = 1'b1; bus.commit_store2_valid = 1'b1;
    tick();                                          // t1
    chk_i("dual_cnt_t1", s_cnt, exp_cnts[0]);
    for (int i = 1; i < 5; i++) begin                // t2..t5
      tick();
      chk_i("dual_cnt", s_cnt, exp_cnts[i]);
      chk_i("dual_beat_valid", int'(s_valid), 1);
    end
    tick();                                          // t6
    chk_i("dual_valid_t6", int'(s_valid), 0);
    chk_i("dual_beats", n_acc - acc0, 4);

    // Uncached store with delayed response, second store held back
    apply_reset();
    bus.dc_req_ready = 1'b1;
    push_entry(1'b1);
    push_entry(1'b0);
    e1 = sq_q[1];
    bus.commit_store1_valid = 1'b1;
    tick();                                          // t0
    bus.commit_store1_valid = 1'b1;
    tick();                                          // t1 pop uncached
    tick();                                          // t2 accepted
    chk_i("unc_valid_t2", int'(s_valid), 1);
    for (int i = 0; i < 5; i++) begin                // t3..t7 waiting
      bus.dc_resp_valid = (i == 4);
      tick();
      chk_i("unc_wait_nopop", int'(s_pop), 0);
      chk_i("unc_wait_novalid", int'(s_valid), 0);
      chk_i("unc_wait_cnt", s_cnt, 1);
    end
    tick();                                          // t8
    chk_i("unc_pop_after_resp", int'(s_pop), 1);
    tick();                                          // t9
    chk_i("unc_second_valid", int'(s_valid), 1);
    chk_e("unc_second_req", s_req, e1);
    drain("unc");

    // Ready held low for 3 cycles
    apply_reset();
    bus.dc_req_ready = 1'b0;
    push_entry(1'b0);
    e0 = sq_q[0];
    pops0 = n_pops; acc0 = n_acc;
    bus.commit_store1_valid = 1'b1;
    tick();                                          // t0
    tick();                                          // t1 pop
    for (int i = 0; i < 3; i++) begin                // t2..t4 stalled
      tick();
      chk_i("stall_valid", int'(s_valid), 1);
      chk_e("stall_stable", s_req, e0);
    end
    bus.dc_req_ready = 1'b1;
    tick();                                          // t5 accepted
    tick();                                          // t6
    chk_i("stall_valid_after", int'(s_valid), 0);
    chk_i("stall_one_pop", n_pops - pops0, 1);
    chk_i("stall_one_beat", n_acc - acc0, 1);

    // Fill to PENDING_MAX-1 then commit and pop on the same cycle
    apply_reset();
    bus.dc_req_ready = 1'b0;
    repeat (9) push_entry(1'b0);
    bus.commit_store1_valid = 1'b1;
    tick();                                          // t0
    bus.commit_store1_valid = 1'b1; bus.commit_store2_valid = 1'b1;
    tick();                                          // t1 pop, cnt 1
    bus.commit_store1_valid = 1'b1; bus.commit_store2_valid = 1'b1;
    tick();                                          // t2 cnt 2
    bus.commit_store1_valid = 1'b1; bus.commit_store2_valid = 1'b1;
    tick();                                          // t3 cnt 4
    bus.commit_store1_valid = 1'b1;
    tick();                                          // t4 cnt 6
    chk_i("full_cnt6", s_cnt, 6);
    chk_i("full_not_yet", int'(s_full), 0);
    bus.commit_store1_valid = 1'b1;
    bus.dc_req_ready = 1'b1;
    tick();                                          // t5 cnt 7, +1 and pop
    chk_i("full_cnt7", s_cnt, 7);
    chk_i("full_flag", int'(s_full), 1);
    chk_i("full_pop", int'(s_pop), 1);
    tick();                                          // t6
    chk_i("full_cnt_unchanged", s_cnt, 7);
    drain("full");

    // Reset in the middle of a request
    apply_reset();
    bus.dc_req_ready = 1'b0;
    push_entry(1'b0);
    push_entry(1'b0);
    bus.commit_store1_valid = 1'b1; bus.commit_store2_valid = 1'b1;
    tick();                                          // t0
    tick();                                          // t1 pop
    tick();                                          // t2 REQ
    chk_i("midrst_valid_before", int'(s_valid), 1);
    chk_i("midrst_cnt_before", s_cnt, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk_i("midrst_valid", int'(bus.dc_req_valid), 0);
    chk_i("midrst_cnt", int'(bus.pending_cnt), 0);
    reset_env();
    repeat (2) tick();
    resetn = 1'b1;
    bus.dc_req_ready = 1'b1;
    push_entry(1'b0);
    acc0 = n_acc;
    bus.commit_store1_valid = 1'b1;
    tick();
    repeat (3) tick();
    chk_i("midrst_resume_beat", n_acc - acc0, 1);
    drain("midrst");

    // Randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (sq_q.size() < 16 && $urandom_range(0, 1) == 1) push_entry($urandom_range(0, 3) == 0);
      avail = sq_q.size() - m_pend;
      if (avail < 0) avail = 0;
      n = 0;
      if (m_pend < PENDING_MAX - 1) n = $urandom_range(0, 2);
      if (n > avail) n = avail;
      bus.commit_store1_valid = (n >= 1);
      bus.commit_store2_valid = (n == 2);
      bus.dc_req_ready        = ($urandom_range(0, 3) != 0);
      bus.dc_resp_valid       = m_wait ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
      tick();
    end
    drain("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
